// File: rtl/div_pkg.sv
// div_pkg: shared widths, step indices, FSM states and operand constants for the divider.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 36;
    localparam int ITER_LO   = 1;
    localparam int ITER_HI   = 32;
    localparam int DONE_STEP = 35;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring-division iteration (shift in a dividend bit, trial subtract, restore).
module div_restore_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] mag_b,
    input  logic             next_bit,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] diff;
    // The remainder stays below mag_b, so the shifted value minus mag_b fits in WIDTH+1 signed bits.
    assign diff     = {rem, next_bit} - {1'b0, mag_b};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : {rem[WIDTH-2:0], next_bit};
endmodule

// File: rtl/div_iter_datapath.sv
// div_iter_datapath: signed restoring divider stepped by a one-hot sequencer, one quotient bit per step.
// Define DIV_REMAINDER_EN to add the signed data_remainder output.
module div_iter_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int STEPS = DIV_STEPS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [STEPS-1:0] step_onehot,
    input  logic             count_done,
    output logic [WIDTH-1:0] data_result,
`ifdef DIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    div_state_t state, state_nx;
    logic [WIDTH-1:0] mag_a, mag_b, rem, rem_nx, quot;
    logic [CW-1:0] iter_cnt;
    logic s_a, s_b, zero_div, ovf, fault, q_bit, multi, iterate, exc, finish;
    assign multi   = |(step_onehot & (step_onehot - STEPS'(1)));
    assign iterate = state == RUN && !count_done && !multi && |step_onehot[ITER_HI:ITER_LO] && iter_cnt < CW'(WIDTH);
    assign finish  = state == RUN && count_done && !ctrl_DIV;
    assign exc     = zero_div | ovf | fault | (iter_cnt != CW'(WIDTH));
    assign busy           = state == RUN;
    assign data_resultRDY = state == DONE;
    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .mag_b    (mag_b),
        .next_bit (mag_a[WIDTH-1]),
        .rem_next (rem_nx),
        .q_bit    (q_bit)
    );
    always_comb begin
        state_nx = ctrl_DIV ? RUN : (state == RUN) ? (count_done ? DONE : RUN) : IDLE;
    end
    // Results are captured on the count_done edge so they are valid throughout the DONE cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            mag_a          <= '0;
            mag_b          <= '0;
            rem            <= '0;
            quot           <= '0;
            iter_cnt       <= '0;
            s_a            <= 1'b0;
            s_b            <= 1'b0;
            zero_div       <= 1'b0;
            ovf            <= 1'b0;
            fault          <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
            data_remainder <= '0;
`endif
        end else begin
            state <= state_nx;
            if (ctrl_DIV) begin
                mag_a    <= data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
                mag_b    <= data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
                s_a      <= data_operandA[WIDTH-1];
                s_b      <= data_operandB[WIDTH-1];
                rem      <= '0;
                quot     <= '0;
                iter_cnt <= '0;
                fault    <= 1'b0;
                zero_div <= data_operandB == '0;
                ovf      <= data_operandA == INT_MIN && data_operandB == NEG_ONE;
            end else begin
                if (state == RUN && multi)
                    fault <= 1'b1;
                if (iterate) begin
                    mag_a    <= mag_a << 1;
                    rem      <= rem_nx;
                    quot     <= {quot[WIDTH-2:0], q_bit};
                    iter_cnt <= iter_cnt + CW'(1);
                end
            end
            if (finish) begin
                data_result    <= exc ? '0 : (s_a ^ s_b) ? -quot : quot;
                data_exception <= exc;
`ifdef DIV_REMAINDER_EN
                data_remainder <= exc ? '0 : s_a ? -rem : rem;
`endif
            end
        end
    end
endmodule

// File: tb/tb_div_iter_datapath.sv
// tb_div_iter_datapath: randomized and directed checks against a plain-arithmetic division model.
module tb_div_iter_datapath;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [35:0] step_onehot = '0;
    logic        count_done = 1'b0;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;
`ifdef DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif
    int pass_cnt = 0;
    int total = 0;
    int rdy_cnt = 0;

    div_iter_datapath dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .step_onehot    (step_onehot),
        .count_done     (count_done),
        .data_result    (data_result),
`ifdef DIV_REMAINDER_EN
        .data_remainder (data_remainder),
`endif
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (data_resultRDY) rdy_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV = 1'b0;
    endtask

    task automatic run_steps(input int n, input int bad);
        for (int s = 0; s < n; s++) begin
            step_onehot = (s == bad) ? 36'h3 : (36'h1 << s);
            tick();
        end
        step_onehot = '0;
    endtask

    task automatic finish_op(output logic [31:0] res, output logic [31:0] rem_o, output logic exc,
                             output logic rdy_pre, output logic rdy, output logic bsy, output logic rdy_post);
        step_onehot = '0;
        count_done = 1'b1;
        rdy_pre = data_resultRDY;
        tick();
        count_done = 1'b0;
        res = data_result;
        exc = data_exception;
        rdy = data_resultRDY;
        bsy = busy;
`ifdef DIV_REMAINDER_EN
        rem_o = data_remainder;
`else
        rem_o = '0;
`endif
        tick();
        rdy_post = data_resultRDY;
    endtask

    // Reference: truncating signed division with remainder taking the dividend's sign.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input int iters, input bit flt,
                                  output logic [31:0] q, output logic [31:0] r, output logic e);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e = (b == 0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || flt || iters != 32;
        q = e ? 32'h0 : 32'(sa / sb);
        r = e ? 32'h0 : 32'(sa % sb);
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        total++; if (data_result !== 32'h0) $display("FAIL reset_result got %h want 0", data_result); else pass_cnt++;
        total++; if (data_exception !== 1'b0) $display("FAIL reset_exc got %b want 0", data_exception); else pass_cnt++;
        total++; if (data_resultRDY !== 1'b0) $display("FAIL reset_rdy got %b want 0", data_resultRDY); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_divide();
        logic [31:0] as[$], bs[$];
        logic [31:0] q, r, res, rem_o;
        logic e, exc, rdy_pre, rdy, bsy, rdy_post;
        as = '{32'd100, -32'sd100, 32'd100, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        bs = '{32'd7, 32'd7, -32'sd7, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
        for (int i = 0; i < 16; i++) begin
            as.push_back($urandom);
            bs.push_back((i % 3 == 0) ? $urandom : (($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 60)) : 32'($urandom_range(1, 60))));
        end
        foreach (as[i]) begin
            model(as[i], bs[i], 32, 1'b0, q, r, e);
            start_op(as[i], bs[i]);
            total++; if (busy !== 1'b1) $display("FAIL div_busy[%0d] got %b want 1", i, busy); else pass_cnt++;
            run_steps(36, -1);
            finish_op(res, rem_o, exc, rdy_pre, rdy, bsy, rdy_post);
            total++; if (rdy_pre !== 1'b0) $display("FAIL div_rdy_early[%0d] got %b want 0", i, rdy_pre); else pass_cnt++;
            total++; if (rdy !== 1'b1) $display("FAIL div_rdy[%0d] got %b want 1", i, rdy); else pass_cnt++;
            total++; if (bsy !== 1'b0) $display("FAIL div_busy_done[%0d] got %b want 0", i, bsy); else pass_cnt++;
            total++; if (res !== q) $display("FAIL div_result[%0d] %h/%h got %h want %h", i, as[i], bs[i], res, q); else pass_cnt++;
            total++; if (exc !== e) $display("FAIL div_exc[%0d] %h/%h got %b want %b", i, as[i], bs[i], exc, e); else pass_cnt++;
`ifdef DIV_REMAINDER_EN
            total++; if (rem_o !== r) $display("FAIL div_rem[%0d] %h/%h got %h want %h", i, as[i], bs[i], rem_o, r); else pass_cnt++;
`endif
            total++; if (rdy_post !== 1'b0) $display("FAIL div_rdy_pulse[%0d] got %b want 0", i, rdy_post); else pass_cnt++;
        end
    endtask

    task automatic test_fault();
        logic [31:0] q, r, res, rem_o;
        logic e, exc, rdy_pre, rdy, bsy, rdy_post;
        model(32'd1000, 32'd3, 31, 1'b1, q, r, e);
        start_op(32'd1000, 32'd3);
        run_steps(36, 1);
        finish_op(res, rem_o, exc, rdy_pre, rdy, bsy, rdy_post);
        total++; if (exc !== e || rdy !== 1'b1) $display("FAIL multihot_exc got exc=%b rdy=%b want exc=%b rdy=1", exc, rdy, e); else pass_cnt++;
        total++; if (res !== q) $display("FAIL multihot_result got %h want %h", res, q); else pass_cnt++;
        model(32'd1000, 32'd3, 19, 1'b0, q, r, e);
        start_op(32'd1000, 32'd3);
        run_steps(20, -1);
        finish_op(res, rem_o, exc, rdy_pre, rdy, bsy, rdy_post);
        total++; if (exc !== e || rdy !== 1'b1) $display("FAIL short_exc got exc=%b rdy=%b want exc=%b rdy=1", exc, rdy, e); else pass_cnt++;
        total++; if (res !== q) $display("FAIL short_result got %h want %h", res, q); else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [31:0] res, rem_o;
        logic exc, rdy_pre, rdy, bsy, rdy_post;
        int base;
        base = rdy_cnt;
        start_op(32'd1000, 32'd3);
        run_steps(10, -1);
        step_onehot = 36'h1 << 10;
        data_operandA = 32'd77;
        data_operandB = 32'd7;
        ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV = 1'b0;
        run_steps(36, -1);
        finish_op(res, rem_o, exc, rdy_pre, rdy, bsy, rdy_post);
        total++; if (res !== 32'd11 || exc !== 1'b0) $display("FAIL abort_result got %h exc=%b want 0000000b exc=0", res, exc); else pass_cnt++;
        total++; if (rdy_cnt - base !== 1) $display("FAIL abort_pulses got %0d want 1", rdy_cnt - base); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, rem_o;
        logic exc, rdy_pre, rdy, bsy, rdy_post;
        start_op(32'd84, 32'd4);
        run_steps(36, -1);
        count_done = 1'b1;
        tick();
        count_done = 1'b0;
        total++; if (data_resultRDY !== 1'b1 || data_result !== 32'd21) $display("FAIL b2b_first got rdy=%b res=%h want rdy=1 res=00000015", data_resultRDY, data_result); else pass_cnt++;
        start_op(32'd50, -32'sd5);
        total++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy); else pass_cnt++;
        run_steps(36, -1);
        finish_op(res, rem_o, exc, rdy_pre, rdy, bsy, rdy_post);
        total++; if (res !== 32'hFFFF_FFF6 || rdy !== 1'b1) $display("FAIL b2b_second got res=%h rdy=%b want fffffff6 rdy=1", res, rdy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res, rem_o;
        logic exc, rdy_pre, rdy, bsy, rdy_post;
        int base;
        base = rdy_cnt;
        start_op(32'd1000, 32'd7);
        run_steps(15, -1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else pass_cnt++;
        total++; if (data_result !== 32'h0) $display("FAIL rstmid_result got %h want 0", data_result); else pass_cnt++;
        count_done = 1'b1;
        tick();
        tick();
        count_done = 1'b0;
        tick();
        total++; if (rdy_cnt - base !== 0) $display("FAIL rstmid_pulses got %0d want 0", rdy_cnt - base); else pass_cnt++;
        start_op(32'd42, 32'd6);
        run_steps(36, -1);
        finish_op(res, rem_o, exc, rdy_pre, rdy, bsy, rdy_post);
        total++; if (res !== 32'd7 || exc !== 1'b0 || rdy !== 1'b1) $display("FAIL rstmid_next got res=%h exc=%b rdy=%b want 00000007 0 1", res, exc, rdy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_divide();
        test_fault();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/div_iter_datapath.md
Name: div_iter_datapath

Overview:
- Iterative signed restoring-division datapath for the processor's multdiv unit.
- Sits directly downstream of the one-hot divide step sequencer and consumes its 36-bit one-hot step vector and its done strobe.
- Produces one quotient bit per active step and delivers a signed 32-bit quotient, exception flag and one-cycle ready pulse.

Parameters:
- WIDTH, 32, operand/quotient width; the arithmetic rules below are written for 32.
- STEPS, 36, width of the sequencer's one-hot step vector; WIDTH+4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset; reset=0 at a rising clk edge clears all state
- ctrl_DIV  input  1  start pulse; operands are sampled on this cycle
- data_operandA  input  WIDTH  signed dividend
- data_operandB  input  WIDTH  signed divisor
- step_onehot  input  STEPS  one-hot step vector from the sequencer
- count_done  input  1  sequencer final-step strobe
- data_result  output  WIDTH  signed quotient; held until next ctrl_DIV
- data_exception  output  1  divide-by-zero, overflow or sequencing fault
- data_resultRDY  output  1  one-cycle pulse when data_result/data_exception are valid
- busy  output  1  high from the cycle after ctrl_DIV until data_resultRDY

Behaviour:
- Reset values: data_result=0, data_exception=0, data_resultRDY=0, busy=0, FSM=IDLE, iter_cnt=0.
- FSM has three states: IDLE, RUN, DONE.
- ctrl_DIV=1 in any state, including RUN (abort and restart):
  - latch magA=|A|, magB=|B| as unsigned WIDTH, and the sign bits sA and sB;
  - clear rem (WIDTH+1 bits), quot and iter_cnt;
  - set zero_div = (B==0) and ovf = (A==32'h80000000 && B==32'hFFFFFFFF);
  - next state RUN; busy=1 the next cycle.
- RUN, iterate cycle: any of step_onehot[32:1] high and iter_cnt<32.
  - rem' = {rem[WIDTH-1:0], magA[31-iter_cnt]}.
  - If rem' >= {1'b0,magB}, then rem=rem'-magB and quotient bit=1; else rem=rem' and quotient bit=0.
  - The quotient bit shifts into the quot LSB; iter_cnt increments.
- RUN, no-op: step_onehot bits 0, 33 and 34, and all-zero cycles. State is held.
- RUN, fault: if step_onehot has more than one bit set, set fault=1 (sticky until next ctrl_DIV) and perform no iteration that cycle.
- RUN with count_done=1: next state DONE. count_done takes priority over a simultaneous iterate bit.
- DONE lasts one cycle:
  - data_resultRDY=1, busy=0.
  - exc = zero_div | ovf | fault | (iter_cnt!=32).
  - If exc: data_result=0 and data_exception=1.
  - Else: data_result = (sA^sB) ? -quot : quot, and data_exception=0.
  - Next state IDLE.
- count_done in IDLE or DONE is ignored.
- ctrl_DIV in the same cycle as DONE: the DONE outputs still fire, and the new operation starts (RUN next).
- Latency: data_resultRDY appears exactly one cycle after the count_done cycle.
- Reset mid-RUN returns to IDLE with all outputs zero. No ready pulse is emitted for the aborted operation.

Optional Feature:
- Macro: DIV_REMAINDER_EN.
- Defined:
  - adds output port data_remainder, WIDTH bits;
  - value = sA ? -rem[WIDTH-1:0] : rem[WIDTH-1:0], so the remainder takes the sign of the dividend;
  - updated in DONE, 0 on exception and reset, held like data_result.
- Undefined: the port is absent and rem is internal only.

Decomposition:
- Package div_pkg holds:
  - DIV_WIDTH=32, DIV_STEPS=36;
  - localparams for the iterate range (ITER_LO=1, ITER_HI=32) and the DONE step index 35;
  - FSM state enum {IDLE, RUN, DONE};
  - constants INT_MIN=32'h80000000 and NEG_ONE=32'hFFFFFFFF.
- One sub-module, div_restore_step: combinational compare-subtract-shift of one iteration.
  - Inputs rem, magB, next dividend bit.
  - Outputs new rem and quotient bit.
- The FSM and registers stay in the top module.

Test Plan:
- A=100, B=7, sequencer drives steps 0..35 one per cycle, then count_done -> one cycle later RDY=1, result=14, exception=0, remainder=2 (feature on).
- A=-100, B=7 -> result=-14 (32'hFFFFFFF2), remainder=-2; A=100, B=-7 -> result=-14, remainder=2.
- A=5, B=0 -> RDY=1, exception=1, result=0; then A=32'h80000000, B=-1 -> exception=1, result=0.
- Start 1000/3, assert ctrl_DIV with 77/7 at step 10, restart sequencer -> a single RDY pulse with result=11. No RDY for 1000/3.
- Inject step_onehot=36'h3 at step 1, or assert count_done after only 20 steps -> exception=1, result=0.
- Reset=0 at step 15 of an operation -> busy=0, RDY never pulses; a later 42/6 run yields 7.
